// File: rtl/rotary_encoder_pulse_gen.sv
// EC11 rotary encoder front end: 2-FF sync + per-contact debounce on A/B/D, Gray-sequence detent decoder.
// Outputs: one-cycle Right/Left pulse per full detent, registered debounced push-switch level.
module rotary_encoder_pulse_gen #(
  parameter  int DEBOUNCE_CYCLES = 1000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic key_a,
  input  logic key_b,
  input  logic key_d,
  output logic Right_pulse,
  output logic Left_pulse,
  output logic d_pulse
);

  typedef enum logic [2:0] {
    IDLE,
    R1,
    R2,
    R3,
    L1,
    L2,
    L3,
    WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel index: 0 = A, 1 = B, 2 = D
  logic [2:0]       raw;
  logic [2:0]       sync1_q;
  logic [2:0]       sync2_q;
  logic [2:0]       deb_q;
  logic [2:0]       deb_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  logic [1:0] ab;
  logic [1:0] ab_prev_q;
  state_t     state_q;
  state_t     state_d;
  logic       right_d;
  logic       left_d;
  logic       right_q;
  logic       left_q;
  logic       d_pulse_q;

  assign raw = {key_d, key_b, key_a};
  assign ab  = {deb_q[0], deb_q[1]};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Any return to the debounced value before expiry restarts the count
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      deb_q <= 3'b111;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // The decoder only advances when the debounced A/B code actually changes
  always_comb begin
    state_d = state_q;
    right_d = 1'b0;
    left_d  = 1'b0;
    if (ab != ab_prev_q) begin
      case (state_q)
        IDLE: begin
          if (ab == 2'b01)      state_d = R1;
          else if (ab == 2'b10) state_d = L1;
          else if (ab == 2'b00) state_d = WAIT;
        end
        R1: begin
          if (ab == 2'b00)      state_d = R2;
          else if (ab == 2'b11) state_d = IDLE;
          else if (ab == 2'b10) state_d = WAIT;
        end
        R2: begin
          if (ab == 2'b10)      state_d = R3;
          else if (ab == 2'b01) state_d = R1;
          else if (ab == 2'b11) state_d = WAIT;
        end
        R3: begin
          if (ab == 2'b11) begin
            state_d = IDLE;
            right_d = 1'b1;
          end else if (ab == 2'b00) begin
            state_d = R2;
          end else if (ab == 2'b01) begin
            state_d = WAIT;
          end
        end
        L1: begin
          if (ab == 2'b00)      state_d = L2;
          else if (ab == 2'b11) state_d = IDLE;
          else if (ab == 2'b01) state_d = WAIT;
        end
        L2: begin
          if (ab == 2'b01)      state_d = L3;
          else if (ab == 2'b10) state_d = L1;
          else if (ab == 2'b11) state_d = WAIT;
        end
        L3: begin
          if (ab == 2'b11) begin
            state_d = IDLE;
            left_d  = 1'b1;
          end else if (ab == 2'b00) begin
            state_d = L2;
          end else if (ab == 2'b10) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (ab == 2'b11) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      ab_prev_q <= 2'b11;
      right_q   <= 1'b0;
      left_q    <= 1'b0;
      d_pulse_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ab_prev_q <= ab;
      right_q   <= right_d;
      left_q    <= left_d;
      d_pulse_q <= ~deb_q[2];
    end
  end

  assign Right_pulse = right_q;
  assign Left_pulse  = left_q;
  assign d_pulse     = d_pulse_q;

endmodule

// File: tb/tb_rotary_encoder_pulse_gen.sv
// Scoreboard bench: expected output events (kind*1000000 + cycle) are queued at stimulus time
// and compared against events the negedge monitor captures from the DUT outputs.
module tb_rotary_encoder_pulse_gen;

  localparam int DC = 4;
  localparam int K_RIGHT = 0;
  localparam int K_LEFT  = 1000000;
  localparam int K_DRISE = 2000000;
  localparam int K_DFALL = 3000000;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic key_a = 1'b1;
  logic key_b = 1'b1;
  logic key_d = 1'b1;
  logic Right_pulse;
  logic Left_pulse;
  logic d_pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_d = 1'b0;
  int exp_q[$];
  int obs_q[$];

  rotary_encoder_pulse_gen #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .key_a      (key_a),
    .key_b      (key_b),
    .key_d      (key_d),
    .Right_pulse(Right_pulse),
    .Left_pulse (Left_pulse),
    .d_pulse    (d_pulse)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Every high cycle of a pulse is its own event, so a wide pulse shows up as an extra entry
  always @(negedge clk_in) begin
    if (Right_pulse) obs_q.push_back(K_RIGHT + cyc);
    if (Left_pulse)  obs_q.push_back(K_LEFT + cyc);
    if (d_pulse && !prev_d) obs_q.push_back(K_DRISE + cyc);
    if (!d_pulse && prev_d) obs_q.push_back(K_DFALL + cyc);
    prev_d <= d_pulse;
  end

  // Called just after a negedge; the next posedge samples the new values.
  task automatic drive_ab(input logic a, input logic b, input int hold);
    key_a = a;
    key_b = b;
    repeat (hold) @(negedge clk_in);
  endtask

  // A change sampled at edge N reaches deb at N+1+DC; the registered output follows one edge later.
  function automatic int due(input int kind);
    return kind + cyc + 1 + DC + 2;
  endfunction

  task automatic test_reset;
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if (Right_pulse !== 1'b0 || Left_pulse !== 1'b0 || d_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_reset: R=%b L=%b D=%b, required 000", Right_pulse, Left_pulse, d_pulse);
    end
    rst_n_in = 1'b1;
    repeat (20) @(negedge clk_in);
    checks++;
    if (Right_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_right: got %b, required 0", Right_pulse);
    end
    checks++;
    if (Left_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_left: got %b, required 0", Left_pulse);
    end
    checks++;
    if (d_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_d: got %b, required 0", d_pulse);
    end
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_events: got %0d events, required 0", obs_q.size());
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_cw;
    int e;
    int o;
    drive_ab(1'b0, 1'b1, 10);
    drive_ab(1'b0, 1'b0, 10);
    drive_ab(1'b1, 1'b0, 10);
    exp_q.push_back(due(K_RIGHT));
    drive_ab(1'b1, 1'b1, 12);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL cw_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL cw_event: got %0d, required %0d", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic glitch_step(input logic a, input logic b, input int hold);
    drive_ab(~key_a, key_b, 2);
    drive_ab(~key_a, key_b, 6);
    drive_ab(a, b, hold);
  endtask

  task automatic test_ccw_glitch;
    int e;
    int o;
    glitch_step(1'b1, 1'b0, 10);
    glitch_step(1'b0, 1'b0, 10);
    glitch_step(1'b0, 1'b1, 10);
    drive_ab(~key_a, key_b, 2);
    drive_ab(~key_a, key_b, 6);
    exp_q.push_back(due(K_LEFT));
    drive_ab(1'b1, 1'b1, 12);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL ccw_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL ccw_event: got %0d, required %0d", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_partial_and_jump;
    drive_ab(1'b0, 1'b1, 10);
    drive_ab(1'b0, 1'b0, 10);
    drive_ab(1'b0, 1'b1, 10);
    drive_ab(1'b1, 1'b1, 12);
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL partial_reverse: got %0d events, required 0", obs_q.size());
    end
    obs_q.delete();
    drive_ab(1'b0, 1'b0, 10);
    drive_ab(1'b1, 1'b1, 12);
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL two_bit_jump: got %0d events, required 0", obs_q.size());
    end
    obs_q.delete();
    // The decoder must be back in IDLE: a clean detent still counts
    exp_q.push_back(0);
    drive_ab(1'b0, 1'b1, 10);
    drive_ab(1'b0, 1'b0, 10);
    drive_ab(1'b1, 1'b0, 10);
    exp_q[0] = due(K_RIGHT);
    drive_ab(1'b1, 1'b1, 12);
    checks++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL after_jump_cw: got %0d events first %0d, required 1 event %0d",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : -1, exp_q[0]);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_switch;
    int e;
    int o;
    key_d = 1'b0;
    repeat (3) @(negedge clk_in);
    key_d = 1'b1;
    repeat (12) @(negedge clk_in);
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL d_short_press: got %0d events, required 0", obs_q.size());
    end
    obs_q.delete();
    exp_q.push_back(due(K_DRISE));
    key_d = 1'b0;
    repeat (10) @(negedge clk_in);
    exp_q.push_back(due(K_DFALL));
    key_d = 1'b1;
    repeat (12) @(negedge clk_in);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL d_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL d_event: got %0d, required %0d", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid_sequence;
    int e;
    int o;
    key_d = 1'b0;
    drive_ab(1'b0, 1'b1, 10);
    drive_ab(1'b0, 1'b0, 10);
    checks++;
    if (d_pulse !== 1'b1) begin
      errors++;
      $display("FAIL mid_d_before_reset: got %b, required 1", d_pulse);
    end
    #1 rst_n_in = 1'b0;
    #1;
    checks++;
    if (Right_pulse !== 1'b0 || Left_pulse !== 1'b0 || d_pulse !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: R=%b L=%b D=%b, required 000", Right_pulse, Left_pulse, d_pulse);
    end
    key_d = 1'b1;
    repeat (3) @(negedge clk_in);
    #1;
    obs_q.delete();
    exp_q.delete();
    rst_n_in = 1'b1;
    repeat (10) @(negedge clk_in);
    drive_ab(1'b1, 1'b0, 10);
    drive_ab(1'b1, 1'b1, 12);
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL post_reset_no_pulse: got %0d events, required 0", obs_q.size());
    end
    obs_q.delete();
    drive_ab(1'b0, 1'b1, 10);
    drive_ab(1'b0, 1'b0, 10);
    drive_ab(1'b1, 1'b0, 10);
    exp_q.push_back(due(K_RIGHT));
    drive_ab(1'b1, 1'b1, 12);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL post_reset_cw_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL post_reset_cw_event: got %0d, required %0d", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    @(negedge clk_in);
    test_reset();
    test_cw();
    test_ccw_glitch();
    test_partial_and_jump();
    test_switch();
    test_reset_mid_sequence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
